// File: rtl/bus_arbiter_ctrl.sv
// Round-robin fetch/data arbiter driving a four-phase memory/IO bus cycle (IDLE, SETUP, STROBE, HOLD).
// Define INT_ACK_EN to add the interrupt-acknowledge vector-read cycle.
module bus_arbiter_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic [9:0] fetch_addr,
  input  logic       data_req,
  input  logic       data_we,
  input  logic       data_io,
  input  logic [9:0] data_addr,
  input  logic       interrupt,
  output logic       fetch_gnt,
  output logic       data_gnt,
  output logic       done,
  output logic       busy,
  output logic [9:0] bus_addr,
  output logic       CS_,
  output logic       RD_,
  output logic       WR_,
  output logic       IO_CS_,
  output logic       IO_RD_,
  output logic       IO_WR_,
  output logic       cpu_drive,
  output logic       int_ack,
  output logic       vec_valid
);

  localparam logic [9:0] INT_VEC_ADDR = 10'h3FF;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t state;
  logic   cyc_we;
  logic   cyc_io;
  logic   int_cyc;
  logic   last_data;
  logic   int_pend;
  logic   idle;
  logic   fetch_win;

  // Grants are Mealy outputs so they land in the IDLE cycle that samples the request.
  always_comb begin
    idle      = (state == IDLE) && !reset;
    fetch_win = fetch_req && (!data_req || last_data);
    fetch_gnt = idle && !int_pend && fetch_win;
    data_gnt  = idle && !int_pend && data_req && !fetch_win;
  end

`ifdef INT_ACK_EN
  logic int_s_p0;
  logic int_s_p1;
  logic int_s_p2;

  // Two-flop synchronizer plus edge register; a new edge wins over the clear in HOLD entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_s_p0 <= 1'b0;
      int_s_p1 <= 1'b0;
      int_s_p2 <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      int_s_p0 <= interrupt;
      int_s_p1 <= int_s_p0;
      int_s_p2 <= int_s_p1;
      if (int_s_p1 && !int_s_p2)
        int_pend <= 1'b1;
      else if (state == STROBE && int_cyc)
        int_pend <= 1'b0;
    end
  end
`else
  logic unused_interrupt;
  assign unused_interrupt = interrupt;
  assign int_pend         = 1'b0;
  assign int_ack          = 1'b0;
  assign vec_valid        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_addr  <= '0;
      cyc_we    <= 1'b0;
      cyc_io    <= 1'b0;
      int_cyc   <= 1'b0;
      last_data <= 1'b1;
      CS_       <= 1'b1;
      RD_       <= 1'b1;
      WR_       <= 1'b1;
      IO_CS_    <= 1'b1;
      IO_RD_    <= 1'b1;
      IO_WR_    <= 1'b1;
      cpu_drive <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef INT_ACK_EN
      int_ack   <= 1'b0;
      vec_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (int_pend || fetch_gnt || data_gnt) begin
            state <= SETUP;
            busy  <= 1'b1;
            if (int_pend) begin
              bus_addr <= INT_VEC_ADDR;
              cyc_we   <= 1'b0;
              cyc_io   <= 1'b1;
              int_cyc  <= 1'b1;
              IO_CS_   <= 1'b0;
            end else if (fetch_gnt) begin
              bus_addr  <= fetch_addr;
              cyc_we    <= 1'b0;
              cyc_io    <= 1'b0;
              last_data <= 1'b0;
              CS_       <= 1'b0;
            end else begin
              bus_addr  <= data_addr;
              cyc_we    <= data_we;
              cyc_io    <= data_io;
              last_data <= 1'b1;
              cpu_drive <= data_we;
              CS_       <= data_io;
              IO_CS_    <= !data_io;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
          if (cyc_io) begin
            IO_RD_ <= cyc_we;
            IO_WR_ <= !cyc_we;
          end else begin
            RD_ <= cyc_we;
            WR_ <= !cyc_we;
          end
`ifdef INT_ACK_EN
          int_ack <= int_cyc;
`endif
        end
        STROBE: begin
          state  <= HOLD;
          RD_    <= 1'b1;
          WR_    <= 1'b1;
          IO_RD_ <= 1'b1;
          IO_WR_ <= 1'b1;
          done   <= !int_cyc;
`ifdef INT_ACK_EN
          int_ack   <= 1'b0;
          vec_valid <= int_cyc;
`endif
        end
        HOLD: begin
          state     <= IDLE;
          CS_       <= 1'b1;
          IO_CS_    <= 1'b1;
          cpu_drive <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          int_cyc   <= 1'b0;
`ifdef INT_ACK_EN
          vec_valid <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Scoreboard bench for bus_arbiter_ctrl: stimulus queues expected bus cycles, a monitor checks each completed cycle.
module tb_bus_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req, data_req, data_we, data_io, interrupt;
  logic [9:0] fetch_addr, data_addr;
  logic       fetch_gnt, data_gnt, done, busy, cpu_drive, int_ack, vec_valid;
  logic [9:0] bus_addr;
  logic       CS_, RD_, WR_, IO_CS_, IO_RD_, IO_WR_;

  bus_arbiter_ctrl dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_we(data_we), .data_io(data_io), .data_addr(data_addr),
    .interrupt(interrupt),
    .fetch_gnt(fetch_gnt), .data_gnt(data_gnt), .done(done), .busy(busy),
    .bus_addr(bus_addr),
    .CS_(CS_), .RD_(RD_), .WR_(WR_), .IO_CS_(IO_CS_), .IO_RD_(IO_RD_), .IO_WR_(IO_WR_),
    .cpu_drive(cpu_drive), .int_ack(int_ack), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  // kind: 0 = interrupt cycle (no grant), 1 = fetch, 2 = data; gap < 0 means don't care
  typedef struct {
    int         kind;
    logic [9:0] addr;
    logic       we;
    logic       io;
    int         gap;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [9:0] addr, input logic we, input logic io,
                          input int gap);
    txn_t t;
    t.kind = kind; t.addr = addr; t.we = we; t.io = io; t.gap = gap;
    exp_q.push_back(t);
  endtask

  // Expected {CS_,RD_,WR_,IO_CS_,IO_RD_,IO_WR_,cpu_drive,done,int_ack,vec_valid} for phase 1..3
  function automatic logic [9:0] exp_sig(input logic we, input logic io, input logic intr, input int ph);
    logic cs, rd, wr, ics, ird, iwr, dn, ack, vv;
    cs = 1; rd = 1; wr = 1; ics = 1; ird = 1; iwr = 1; dn = 0; ack = 0; vv = 0;
    if (io) ics = 0; else cs = 0;
    if (ph == 2) begin
      if (we) begin if (io) iwr = 0; else wr = 0; end
      else    begin if (io) ird = 0; else rd = 0; end
      ack = intr;
    end
    if (ph == 3) begin
      dn = !intr;
      vv = intr;
    end
    return {cs, rd, wr, ics, ird, iwr, we, dn, ack, vv};
  endfunction

  // Monitor: captures each bus cycle by busy phase and compares against the scoreboard head.
  int         phase = 0, idle_run = 0, prev_kind = 0, prev_idle = 0, cur_kind = 0, cur_idle = 0;
  logic [9:0] cur_addr;
  logic [9:0] sig [1:3];

  always @(negedge clk) begin
    if (reset) begin
      phase    = 0;
      idle_run = 0;
    end else if (busy) begin
      if (fetch_gnt || data_gnt) check("gnt_while_busy", {fetch_gnt, data_gnt}, 2'b00);
      phase++;
      idle_run = 0;
      if (phase == 1) begin
        cur_addr = bus_addr;
        cur_kind = prev_kind;
        cur_idle = prev_idle;
      end else if (bus_addr !== cur_addr) begin
        check("bus_addr_hold", bus_addr, cur_addr);
      end
      if (phase <= 3)
        sig[phase] = {CS_, RD_, WR_, IO_CS_, IO_RD_, IO_WR_, cpu_drive, done, int_ack, vec_valid};
      else
        check("busy_too_long", phase, 3);
      if (phase == 3) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got kind %0d addr %h, expected none", cur_kind, cur_addr);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          check("txn_kind", cur_kind, t.kind);
          check("txn_addr", cur_addr, t.addr);
          for (int p = 1; p <= 3; p++)
            check($sformatf("txn_sig_ph%0d", p), sig[p], exp_sig(t.we, t.io, (t.kind == 0), p));
          if (t.gap >= 0) check("txn_gap", cur_idle, t.gap);
        end
      end
    end else begin
      if (phase != 0 && phase != 3) check("busy_len", phase, 3);
      if (done || vec_valid || int_ack) check("pulse_in_idle", {done, vec_valid, int_ack}, 3'b000);
      if (fetch_gnt && data_gnt) check("double_gnt", {fetch_gnt, data_gnt}, 2'b10);
      prev_kind = fetch_gnt ? 1 : (data_gnt ? 2 : 0);
      prev_idle = idle_run;
      idle_run++;
      phase = 0;
    end
  end

  task automatic wait_grant(input int kind, input int max_lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((kind == 1 && fetch_gnt) || (kind == 2 && data_gnt)) begin
        if (max_lat >= 0 && i > max_lat) check("gnt_latency", i, max_lat);
        return;
      end
    end
    check("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  // Single requester; inputs are scrambled right after the grant edge.
  task automatic run_single(input int kind, input logic [9:0] addr, input logic we, input logic io);
    push_exp(kind, addr, (kind == 1) ? 1'b0 : we, (kind == 1) ? 1'b0 : io, -1);
    @(posedge clk); #1;
    if (kind == 1) begin
      fetch_req = 1; fetch_addr = addr;
    end else begin
      data_req = 1; data_addr = addr; data_we = we; data_io = io;
    end
    wait_grant(kind, 0);
    @(posedge clk); #1;
    fetch_req = 0; data_req = 0;
    fetch_addr = ~addr; data_addr = ~addr; data_we = ~we; data_io = ~io;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1; fetch_req = 1; data_req = 0; data_we = 0; data_io = 0; interrupt = 0;
    fetch_addr = 10'h0; data_addr = 10'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {CS_, RD_, WR_, IO_CS_, IO_RD_, IO_WR_}, 6'b111111);
    check("rst_ctrl", {fetch_gnt, data_gnt, done, busy, cpu_drive, int_ack, vec_valid}, 7'b0);
    check("rst_addr", bus_addr, 10'h000);
    fetch_req = 0;
    @(posedge clk); #1 reset = 0;

    // Basic memory fetch, then single fetch again with last winner = fetch
    run_single(1, 10'h010, 1'b0, 1'b0);
    run_single(1, 10'h011, 1'b0, 1'b0);
    // IO write, memory write, IO read, memory data read
    run_single(2, 10'h020, 1'b1, 1'b1);
    run_single(2, 10'h155, 1'b1, 1'b0);
    run_single(2, 10'h2AA, 1'b0, 1'b1);
    run_single(2, 10'h3FE, 1'b0, 1'b0);

    // A request raised and dropped while busy is never granted
    push_exp(1, 10'h0C3, 1'b0, 1'b0, -1);
    @(posedge clk); #1 fetch_req = 1; fetch_addr = 10'h0C3;
    wait_grant(1, 0);
    @(posedge clk); #1 fetch_req = 0; data_req = 1; data_addr = 10'h111; data_we = 0; data_io = 0;
    @(posedge clk); #1 data_req = 0;
    wait_idle();
    repeat (3) @(posedge clk);

    // Both requesters held from reset: fetch, data, fetch, data back to back
    #1 reset = 1;
    fetch_req = 1; fetch_addr = 10'h100;
    data_req = 1; data_addr = 10'h200; data_we = 0; data_io = 0;
    push_exp(1, 10'h100, 1'b0, 1'b0, -1);
    push_exp(2, 10'h200, 1'b0, 1'b0, 0);
    push_exp(1, 10'h100, 1'b0, 1'b0, 0);
    push_exp(2, 10'h200, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (fetch_gnt || data_gnt) n++;
    end
    check("rr_grant_count", n, 4);
    @(posedge clk); #1 fetch_req = 0; data_req = 0;
    wait_idle();

    // Reset during STROBE of a memory write, request held, re-granted after release
    push_exp(2, 10'h0AA, 1'b1, 1'b0, -1);
    @(posedge clk); #1 data_req = 1; data_addr = 10'h0AA; data_we = 1; data_io = 0;
    wait_grant(2, 0);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_reset_wr", {CS_, WR_, cpu_drive}, 3'b001);
    reset = 1;
    #1;
    check("abort_strobes", {CS_, RD_, WR_, IO_CS_, IO_RD_, IO_WR_}, 6'b111111);
    check("abort_ctrl", {cpu_drive, done, busy}, 3'b000);
    check("abort_addr", bus_addr, 10'h000);
    @(posedge clk); #1 reset = 0;
    #1 check("regrant_after_reset", data_gnt, 1'b1);
    @(posedge clk); #1 data_req = 0;
    wait_idle();

`ifdef INT_ACK_EN
    // Interrupt edge during a fetch: vector read runs next, then the held fetch
    push_exp(1, 10'h040, 1'b0, 1'b0, -1);
    push_exp(0, 10'h3FF, 1'b0, 1'b1, 0);
    push_exp(1, 10'h040, 1'b0, 1'b0, 0);
    @(posedge clk); #1 fetch_req = 1; fetch_addr = 10'h040;
    wait_grant(1, 0);
    interrupt = 1;
    @(posedge clk);
    wait_grant(1, 16);
    @(posedge clk); #1 fetch_req = 0;
    wait_idle();
    interrupt = 0;
`else
    // Interrupt has no effect without the acknowledge feature
    @(posedge clk); #1 interrupt = 1;
    repeat (8) @(posedge clk);
    #1 check("int_ignored", {busy, int_ack, vec_valid}, 3'b000);
    interrupt = 0;
`endif

    repeat (6) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_ctrl.md
BUS_ARBITER_CTRL -- requirements
Module: bus_arbiter_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have ports fetch_req, input, 1, instruction-fetch request; fetch_addr, input, 10, fetch word address.
REQ-004 SHALL have ports data_req, input, 1, data request; data_we, input, 1, 1=write; data_io, input, 1, 1=IO space; data_addr, input, 10, data address.
REQ-005 SHALL have port interrupt, input, 1, IO interrupt line (level, may be asynchronous to access).
REQ-006 SHALL have ports fetch_gnt and data_gnt, output, 1 each, one-cycle grant pulses.
REQ-007 SHALL have ports done, output, 1, one-cycle completion pulse; busy, output, 1, high when FSM not IDLE.
REQ-008 SHALL have port bus_addr, output, 10, address driven to memory/IO.
REQ-009 SHALL have ports CS_, RD_, WR_, IO_CS_, IO_RD_, IO_WR_, output, 1 each, active-low strobes.
REQ-010 SHALL have port cpu_drive, output, 1, 1=CPU drives the data bus (write cycles only).
REQ-011 SHALL have ports int_ack, output, 1, and vec_valid, output, 1 (see REQ-027).

Function
REQ-012 FSM SHALL have states IDLE, SETUP, STROBE, HOLD; IDLE->SETUP on grant, SETUP->STROBE->HOLD->IDLE unconditionally.
REQ-013 Grant SHALL be issued in IDLE in the cycle a request is sampled high; at most one grant per cycle.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; last-winner flag resets to "data", so fetch wins first conflict.
REQ-015 Single requester SHALL be granted immediately regardless of last-winner flag.
REQ-016 Granted address, we, io SHALL be registered at grant; bus_addr SHALL hold that value through SETUP, STROBE, HOLD.
REQ-017 Fetch cycles SHALL always be memory reads (we=0, io=0).
REQ-018 SETUP: selected CS_ (memory) or IO_CS_ (io) low, RD_/WR_ high.
REQ-019 STROBE: chip select low plus RD_ (read) or WR_ (write) low of the selected space; the other space's strobes SHALL stay high.
REQ-020 HOLD: chip select low, RD_/WR_ high, done=1 for exactly this cycle.
REQ-021 cpu_drive SHALL be 1 in SETUP, STROBE, HOLD of write cycles only; 0 otherwise.
REQ-022 Grant-to-done latency SHALL be 3 cycles; next grant earliest in the IDLE cycle after HOLD (4-cycle throughput).
REQ-023 Requests dropped before grant SHALL be ignored; requests changed after grant SHALL not affect the cycle in progress.
REQ-024 Memory and IO strobes SHALL never be low simultaneously.

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, all active-low strobes=1, grants, done, busy, cpu_drive, int_ack, vec_valid=0, bus_addr=0, last-winner=data, int_pend=0.
REQ-026 Reset mid-cycle SHALL abort the access with no done pulse; first grant possible in first clock after reset release.

Configuration
REQ-027 With INT_ACK_EN defined: rising edge of interrupt (2-flop synchronized) SHALL set int_pend; in IDLE int_pend SHALL take priority over both requesters and run an IO read at address 10'h3FF with no grant, int_ack=1 during STROBE, vec_valid=1 (instead of done) during HOLD, int_pend cleared at HOLD; edges during the cycle re-set int_pend.
REQ-028 Without INT_ACK_EN: interrupt SHALL be ignored, int_ack and vec_valid tied 0, no synchronizer or int_pend logic.

Verification
REQ-029 fetch_req=1, addr=10'h010, data_req=0 -> fetch_gnt cycle 0; CS_=0 cycles 1-3; RD_=0 cycle 2 only; done cycle 3; WR_, IO_* high throughout.
REQ-030 data_req=1, we=1, io=1, addr=10'h020 -> IO_CS_=0 cycles 1-3, IO_WR_=0 cycle 2, cpu_drive=1 cycles 1-3, CS_ high.
REQ-031 fetch_req and data_req held high continuously from reset -> grants alternate fetch, data, fetch, data at 4-cycle spacing.
REQ-032 Reset asserted during STROBE of memory write -> WR_, CS_ high and cpu_drive 0 same cycle, no done; after release, held request re-granted next clock.
REQ-033 INT_ACK_EN, interrupt rises while fetch in progress and fetch_req held -> after HOLD, IO read of 10'h3FF, int_ack in STROBE, vec_valid in HOLD, then fetch granted.
